// File: rtl/mul_request_scheduler.sv
// Round-robin scheduler sharing one 32-bit vector multiplier among NUM_REQ requesters.
// A tag pipe follows each issue through the multiplier; results land in a credit-limited FIFO.
module mul_request_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int MUL_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4,
    localparam int ID_W       = $clog2(NUM_REQ),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_operand_a,
    input  logic [NUM_REQ*32-1:0] req_operand_b,
    input  logic [NUM_REQ*2-1:0]  req_precision,
    output logic [31:0]           mul_operand_a,
    output logic [31:0]           mul_operand_b,
    output logic [1:0]            mul_precision,
    input  logic [63:0]           mul_result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [63:0]           rsp_result,
    output logic [ID_W-1:0]       rsp_id,
    output logic [1:0]            rsp_precision,
    output logic [CNT_W-1:0]      outstanding
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [NUM_REQ-1:0][31:0] op_a, op_b;
    logic [NUM_REQ-1:0][1:0]  op_prec;

    assign op_a    = req_operand_a;
    assign op_b    = req_operand_b;
    assign op_prec = req_precision;

    logic [ID_W-1:0] rr_ptr, gnt_idx;
    logic [ID_W:0]   cand;
    logic            can_issue, issue, found;

    // Credits cover both in-flight and queued results, so the FIFO can never overflow.
    assign can_issue = (outstanding < CNT_W'(FIFO_DEPTH));

    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ))
                cand = cand - (ID_W+1)'(NUM_REQ);
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
        if (found && can_issue && !rst)
            req_ready[gnt_idx] = 1'b1;
    end

    assign issue = |req_ready;

    logic [31:0] hold_a, hold_b;
    logic [1:0]  hold_prec;

    // Multiplier inputs follow the winner on issue and otherwise keep the last issued operands.
    always_comb begin
        mul_operand_a = hold_a;
        mul_operand_b = hold_b;
        mul_precision = hold_prec;
        if (rst) begin
            mul_operand_a = '0;
            mul_operand_b = '0;
            mul_precision = '0;
        end else if (issue) begin
            mul_operand_a = op_a[gnt_idx];
            mul_operand_b = op_b[gnt_idx];
            mul_precision = op_prec[gnt_idx];
        end
    end

    logic [MUL_LATENCY:1]           vld_pipe;
    logic [MUL_LATENCY:1][ID_W-1:0] id_pipe;
    logic [MUL_LATENCY:1][1:0]      prec_pipe;

    logic [63:0]      mem_res  [FIFO_DEPTH];
    logic [ID_W-1:0]  mem_id   [FIFO_DEPTH];
    logic [1:0]       mem_prec [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fill;
    logic             wr, pop;

    assign wr            = vld_pipe[MUL_LATENCY];
    assign rsp_valid     = !rst && (fill != '0);
    assign pop           = rsp_valid && rsp_ready;
    assign rsp_result    = mem_res[rd_ptr];
    assign rsp_id        = mem_id[rd_ptr];
    assign rsp_precision = mem_prec[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            vld_pipe    <= '0;
            id_pipe     <= '0;
            prec_pipe   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            outstanding <= '0;
            hold_a      <= '0;
            hold_b      <= '0;
            hold_prec   <= '0;
        end else begin
            if (issue) begin
                rr_ptr    <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
                hold_a    <= op_a[gnt_idx];
                hold_b    <= op_b[gnt_idx];
                hold_prec <= op_prec[gnt_idx];
            end

            vld_pipe[1]  <= issue;
            id_pipe[1]   <= gnt_idx;
            prec_pipe[1] <= op_prec[gnt_idx];
            for (int s = 2; s <= MUL_LATENCY; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                id_pipe[s]   <= id_pipe[s-1];
                prec_pipe[s] <= prec_pipe[s-1];
            end

            if (wr) begin
                mem_res[wr_ptr]  <= mul_result;
                mem_id[wr_ptr]   <= id_pipe[MUL_LATENCY];
                mem_prec[wr_ptr] <= prec_pipe[MUL_LATENCY];
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);

            case ({wr, pop})
                2'b10:   fill <= fill + CNT_W'(1);
                2'b01:   fill <= fill - CNT_W'(1);
                default: fill <= fill;
            endcase

            case ({issue, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase

            a_no_overflow: assert (!(wr && fill == CNT_W'(FIFO_DEPTH)));
        end
    end
endmodule

// File: tb/tb_mul_request_scheduler.sv
// Bench for mul_request_scheduler: directed vector table, corner sequences and a
// randomized run against a queue-based reference model; the bench also plays the multiplier.
module tb_mul_request_scheduler;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [3:0]       req_valid, req_ready;
    logic [3:0][31:0] op_a, op_b;
    logic [3:0][1:0]  op_p;
    logic [31:0]      mul_operand_a, mul_operand_b;
    logic [1:0]       mul_precision;
    logic [63:0]      mul_result = '0;
    logic             rsp_valid, rsp_ready;
    logic [63:0]      rsp_result;
    logic [1:0]       rsp_id, rsp_precision;
    logic [2:0]       outstanding;

    int n_cmp  = 0;
    int n_fail = 0;

    mul_request_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_operand_a(op_a), .req_operand_b(op_b), .req_precision(op_p),
        .mul_operand_a(mul_operand_a), .mul_operand_b(mul_operand_b),
        .mul_precision(mul_precision), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_id(rsp_id), .rsp_precision(rsp_precision), .outstanding(outstanding)
    );

    function automatic logic [63:0] mulf(input logic [31:0] a, input logic [31:0] b, input logic [1:0] p);
        logic [63:0] r;
        r = '0;
        case (p)
            2'b00: for (int i = 0; i < 4; i++) r[16*i+:16] = 16'(a[8*i+:8]) * 16'(b[8*i+:8]);
            2'b01: for (int i = 0; i < 2; i++) r[32*i+:32] = 32'(a[16*i+:16]) * 32'(b[16*i+:16]);
            default: r = 64'(a) * 64'(b);
        endcase
        return r;
    endfunction

    // One-cycle multiplier
    always @(posedge clk) mul_result <= mulf(mul_operand_a, mul_operand_b, mul_precision);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: queues for multiplier pipe and response FIFO, integer credit count
    typedef struct packed { logic v; logic [1:0] id; logic [1:0] prec; logic [63:0] res; } rec_t;
    rec_t        pipe_q[$];
    rec_t        fifo_q[$];
    int          m_rr, m_out;
    logic [31:0] m_la, m_lb;
    logic [1:0]  m_lp;

    task automatic model_reset();
        pipe_q.delete();
        fifo_q.delete();
        pipe_q.push_back('0);
        m_rr = 0; m_out = 0; m_la = '0; m_lb = '0; m_lp = '0;
    endtask

    function automatic int pick();
        int j;
        if (rst || m_out >= 4) return -1;
        for (int k = 0; k < 4; k++) begin
            j = (m_rr + k) % 4;
            if (req_valid[j[1:0]]) return j;
        end
        return -1;
    endfunction

    logic [3:0] seen_ready;
    logic [2:0] seen_out;
    logic       seen_vld;

    task automatic model_check();
        int         g;
        logic [1:0] gi;
        logic [3:0] er;
        g  = pick();
        gi = g[1:0];
        er = (g < 0) ? 4'b0 : (4'b1 << gi);
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(!rst && fifo_q.size() > 0));
        chk("outstanding", 64'(outstanding), 64'(m_out));
        if (!rst && fifo_q.size() > 0) begin
            chk("rsp_result", rsp_result, fifo_q[0].res);
            chk("rsp_id", 64'(rsp_id), 64'(fifo_q[0].id));
            chk("rsp_precision", 64'(rsp_precision), 64'(fifo_q[0].prec));
        end
        if (!rst) begin
            chk("mul_operand_a", 64'(mul_operand_a), 64'((g >= 0) ? op_a[gi] : m_la));
            chk("mul_precision", 64'(mul_precision), 64'((g >= 0) ? op_p[gi] : m_lp));
        end
    endtask

    task automatic model_update();
        int         g;
        logic [1:0] gi;
        rec_t       head, nw;
        if (rst) begin
            model_reset();
            return;
        end
        g    = pick();
        gi   = g[1:0];
        head = pipe_q.pop_front();
        if (fifo_q.size() > 0 && rsp_ready) begin
            void'(fifo_q.pop_front());
            m_out--;
        end
        if (head.v) fifo_q.push_back(head);
        nw = '0;
        if (g >= 0) begin
            nw.v    = 1'b1;
            nw.id   = gi;
            nw.prec = op_p[gi];
            nw.res  = mulf(op_a[gi], op_b[gi], op_p[gi]);
            m_out++;
            m_rr = (g + 1) % 4;
            m_la = op_a[gi]; m_lb = op_b[gi]; m_lp = op_p[gi];
        end
        pipe_q.push_back(nw);
    endtask

    task automatic cycle();
        @(negedge clk);
        model_check();
        seen_ready = req_ready;
        seen_out   = outstanding;
        seen_vld   = rsp_valid;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    typedef struct {
        logic rst; logic [3:0] v; logic [1:0] p; logic [31:0] a, b; logic rdy;
        logic [3:0] e_ready; logic e_vld; logic [1:0] e_id, e_prec; logic [63:0] e_res; logic [2:0] e_out;
    } vec_t;
    vec_t tbl[10];

    int acc;

    initial begin
        tbl[0] = '{1'b1, 4'h0, 2'd2, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 64'h0, 3'd0};
        tbl[1] = '{1'b0, 4'h1, 2'd2, 32'h3, 32'h5, 1'b0, 4'h1, 1'b0, 2'd0, 2'd0, 64'h0, 3'd0};
        tbl[2] = '{1'b0, 4'h0, 2'd2, 32'h3, 32'h5, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 64'h0, 3'd1};
        tbl[3] = '{1'b0, 4'h0, 2'd2, 32'h3, 32'h5, 1'b0, 4'h0, 1'b1, 2'd0, 2'd2, 64'hF, 3'd1};
        tbl[4] = '{1'b0, 4'h0, 2'd2, 32'h3, 32'h5, 1'b1, 4'h0, 1'b1, 2'd0, 2'd2, 64'hF, 3'd1};
        tbl[5] = '{1'b0, 4'h0, 2'd2, 32'h3, 32'h5, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 64'h0, 3'd0};
        tbl[6] = '{1'b0, 4'h4, 2'd0, 32'h0403_0201, 32'h0101_0101, 1'b0, 4'h4, 1'b0, 2'd0, 2'd0, 64'h0, 3'd0};
        tbl[7] = '{1'b0, 4'h0, 2'd0, 32'h0403_0201, 32'h0101_0101, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 64'h0, 3'd1};
        tbl[8] = '{1'b0, 4'h0, 2'd0, 32'h0403_0201, 32'h0101_0101, 1'b1, 4'h0, 1'b1, 2'd2, 2'd0,
                   64'h0004_0003_0002_0001, 3'd1};
        tbl[9] = '{1'b0, 4'h0, 2'd0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 2'd0, 2'd0, 64'h0, 3'd0};

        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; op_a = '0; op_b = '0; op_p = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int r = 0; r < 10; r++) begin
            rst = tbl[r].rst; req_valid = tbl[r].v; rsp_ready = tbl[r].rdy;
            for (int i = 0; i < 4; i++) begin
                op_a[i] = tbl[r].a; op_b[i] = tbl[r].b; op_p[i] = tbl[r].p;
            end
            @(negedge clk);
            chk($sformatf("tbl%0d_req_ready", r), 64'(req_ready), 64'(tbl[r].e_ready));
            chk($sformatf("tbl%0d_rsp_valid", r), 64'(rsp_valid), 64'(tbl[r].e_vld));
            chk($sformatf("tbl%0d_outstanding", r), 64'(outstanding), 64'(tbl[r].e_out));
            if (tbl[r].e_vld) begin
                chk($sformatf("tbl%0d_rsp_result", r), rsp_result, tbl[r].e_res);
                chk($sformatf("tbl%0d_rsp_id", r), 64'(rsp_id), 64'(tbl[r].e_id));
                chk($sformatf("tbl%0d_rsp_precision", r), 64'(rsp_precision), 64'(tbl[r].e_prec));
            end
            @(posedge clk);
            #1;
        end

        // Resynchronise the model with the DUT
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Everybody requesting, consumer always ready: strict rotation
        for (int i = 0; i < 4; i++) begin op_a[i] = 32'(i + 1); op_b[i] = 32'h10; op_p[i] = 2'd2; end
        req_valid = 4'hF; rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("rotation_grant", 64'(seen_ready), 64'(4'b1 << (i % 4)));
        end

        // Consumer stalled: credit stops issue at four
        do_reset();
        req_valid = 4'hF; rsp_ready = 1'b0; acc = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (seen_ready != 0) acc++;
        end
        chk("stall_accepts", 64'(acc), 64'd4);
        chk("stall_outstanding", 64'(seen_out), 64'd4);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0; acc = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (seen_ready != 0) acc++;
        end
        chk("one_pop_one_accept", 64'(acc), 64'd1);

        // Full FIFO then pop and request together
        req_valid = 4'h0;
        repeat (2) cycle();
        req_valid = 4'hF; rsp_ready = 1'b1;
        cycle();
        chk("full_no_grant", 64'(seen_ready), 64'd0);
        cycle();
        chk("pop_and_issue_grant", 64'(seen_ready != 0), 64'd1);
        cycle();
        chk("pop_and_issue_credit", 64'(seen_out), 64'd3);

        // Reset with work in flight and queued
        do_reset();
        req_valid = 4'hF; rsp_ready = 1'b0;
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; req_valid = 4'h0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("post_reset_rsp_valid", 64'(seen_vld), 64'd0);
            chk("post_reset_outstanding", 64'(seen_out), 64'd0);
        end
        req_valid = 4'hF;
        cycle();
        chk("post_reset_rr_ptr", 64'(seen_ready), 64'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 39) == 0);
            req_valid = 4'($urandom);
            rsp_ready = (c < 200) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 4; i++) begin
                op_a[i] = $urandom; op_b[i] = $urandom; op_p[i] = 2'($urandom);
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
